turn_queue: RTL and testbench
=============================

// Module: turn_queue
// PURPOSE
//  Upstream of the pacman mover: sits between the USB keycode register and pacman's keycode input.
//  Decodes WASD into a 2-bit direction and holds the current direction.
//  Buffers ("pre-turns") a perpendicular request until the sprite is tile-aligned, so turns land on grid.
//  Drives a clean, held keycode to pacman; reversals pass through at once.
// PARAMETERS
//  TILE_LOG2      3    tile edge = 2**TILE_LOG2 px; alignment = low TILE_LOG2 bits of X and Y all zero
//  ALIGN_LEAD     2    px of look-ahead, compensating pacman's 1-frame motion-register lag plus this block's output register
//  QUEUE_TIMEOUT  32   frames a pending turn survives without alignment before it is dropped
// PORTS
//  frame_clk      in   1   frame-rate clock, the same one pacman uses
//  Reset_n        in   1   synchronous, active-low reset
//  keycode        in   8   raw USB HID keycode
//  BallX, BallY   in   10  pacman position, fed back from the pacman outputs
//  isDefeated     in   1   life lost: flush to idle
//  death          in   1   game over: hold idle, ignore keys
//  keycode_out    out  8   registered keycode to pacman (04/07/16/1A, or 00)
//  cur_dir        out  2   direction being driven: 0=R 1=D 2=L 3=U, matching last_keypress
//  pend_valid     out  1   a queued turn is waiting
//  pend_dir       out  2   queued direction; meaningless when pend_valid=0
// BEHAVIOUR
//  Reset (Reset_n=0 at an edge): state=IDLE, keycode_out=00, cur_dir=0, pend_valid=0, pend_dir=0, timer=0.
//  Decode: 07->R, 16->D, 04->L, 1A->U. Any other code, including 00, is "no key" and changes nothing.
//  Latency: keycode is sampled at edge n; keycode_out, cur_dir and pend_* change at edge n; pacman acts at edge n+1.
//  Output rule: keycode_out is the code of cur_dir in MOVING/PENDING and 00 in IDLE. It is held every frame, not pulsed.
//  Alignment test:
//   - Predicted position = BallX/BallY + ALIGN_LEAD*d(cur_dir), in 10-bit two's-complement modulo-1024 arithmetic.
//   - d(R)=(+1,0), d(L)=(-1,0), d(D)=(0,+1), d(U)=(0,-1).
//   - aligned = low TILE_LOG2 bits of both predicted X and predicted Y are zero.
//  States:
//   IDLE:
//    - Any valid key -> MOVING with cur_dir = key.
//    - First move needs no alignment.
//   MOVING:
//    - key == cur_dir: no change.
//    - key == opposite(cur_dir): cur_dir = key at once; stay MOVING.
//    - Perpendicular key with aligned=1: cur_dir = key; stay MOVING.
//    - Perpendicular key with aligned=0: pend_dir = key, pend_valid=1, timer=0 -> PENDING.
//   PENDING (each edge, in priority order):
//    1. Opposite(cur_dir) key: apply the reversal, clear pend -> MOVING.
//    2. Other perpendicular key differing from pend_dir: replace pend_dir, timer=0.
//    3. aligned=1: cur_dir = pend_dir, pend_valid=0 -> MOVING. This takes effect the same edge as a key equal to cur_dir or pend_dir.
//    4. timer == QUEUE_TIMEOUT-1: drop the pend, pend_valid=0 -> MOVING.
//    5. Otherwise timer++. The timer is saturating, width clog2(QUEUE_TIMEOUT).
//  isDefeated=1 at an edge: same values as reset. It has priority over keys.
//  death=1: same values as reset, held while death=1; keys are ignored. Priority: Reset_n > death > isDefeated > keys.
//  Simultaneous events: when aligned and timeout coincide, alignment wins and the turn is taken.
//  Wrap-around: predicted X near 0 or 1023 wraps modulo 1024. No clamping; the wall module owns bounds.
// STRUCTURE
//  Shared package pacman_pkg:
//   - typedef enum logic[1:0] dir_t {DIR_R, DIR_D, DIR_L, DIR_U}
//   - KEY_W=8'h1A, KEY_A=8'h04, KEY_S=8'h16, KEY_D=8'h07
//   - function opposite(dir_t)
//   - function dir_to_key(dir_t)
//   - typedef enum tq_state_t {TQ_IDLE, TQ_MOVING, TQ_PENDING}
//  One combinational sub-module, key_decode: keycode -> {valid, dir_t}. It is shared later with the ghost AI test harness.
//  Everything else is one always_ff (state, cur_dir, pend, timer, keycode_out) plus an always_comb next-state and aligned logic.
// TESTING
//  1. Reset_n=0 for 2 edges, then keycode=07 -> next edge keycode_out=07, cur_dir=0. In IDLE, no alignment is needed.
//  2. Moving R, BallX=133, BallY=248, key 16 -> pend_valid=1, pend_dir=1, keycode_out stays 07.
//     Advance BallX to 134 (predicted 136, aligned) -> keycode_out=16, pend_valid=0.
//  3. Moving R, BallX=131, key 04 (reversal) -> keycode_out=04 on the next edge, with no pend.
//  4. Moving R, misaligned, key 1A, then keys held at 00 for 32 edges with no alignment -> pend_valid drops after exactly 32 edges, keycode_out=07.
//  5. While PENDING, isDefeated=1 for 1 edge -> keycode_out=00, pend_valid=0, state IDLE. Then keycode=04 -> keycode_out=04.
//  6. death=1 with keycode=07 held -> keycode_out stays 00. Reset_n=0 during PENDING -> all outputs at reset values on that edge.

Source files
------------

// File: rtl/pacman_pkg.sv
// pacman_pkg: shared direction/key encodings and turn-queue state type.
package pacman_pkg;
    typedef enum logic [1:0] {DIR_R, DIR_D, DIR_L, DIR_U} dir_t;
    typedef enum logic [1:0] {TQ_IDLE, TQ_MOVING, TQ_PENDING} tq_state_t;
    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;
    // R<->L and D<->U differ only in the upper encoding bit
    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction
    function automatic logic [7:0] dir_to_key(dir_t d);
        return d == DIR_R ? KEY_D : d == DIR_D ? KEY_S : d == DIR_L ? KEY_A : KEY_W;
    endfunction
endpackage

// File: rtl/turn_queue_if.sv
// turn_queue_if: keycode/position inputs and held-direction outputs of the turn queue.
interface turn_queue_if;
    import pacman_pkg::*;
    logic [7:0] keycode;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic       isDefeated;
    logic       death;
    logic [7:0] keycode_out;
    dir_t       cur_dir;
    logic       pend_valid;
    dir_t       pend_dir;
    modport master (output keycode, BallX, BallY, isDefeated, death,
                    input keycode_out, cur_dir, pend_valid, pend_dir);
    modport slave  (input keycode, BallX, BallY, isDefeated, death,
                    output keycode_out, cur_dir, pend_valid, pend_dir);
endinterface

// File: rtl/key_decode.sv
// key_decode: WASD HID keycode to {valid, direction}; anything else is no key.
module key_decode
    import pacman_pkg::*;
(
    input  logic [7:0] keycode_i,
    output logic       valid_o,
    output dir_t       dir_o
);
    always_comb begin
        valid_o = keycode_i == KEY_D || keycode_i == KEY_S || keycode_i == KEY_A || keycode_i == KEY_W;
        dir_o   = keycode_i == KEY_S ? DIR_D : keycode_i == KEY_A ? DIR_L : keycode_i == KEY_W ? DIR_U : DIR_R;
    end
endmodule

// File: rtl/turn_queue.sv
// turn_queue: holds pacman's direction and defers perpendicular turns until the
// sprite (predicted ALIGN_LEAD px ahead) sits on a tile corner.
module turn_queue
    import pacman_pkg::*;
#(
    parameter int TILE_LOG2     = 3,
    parameter int ALIGN_LEAD    = 2,
    parameter int QUEUE_TIMEOUT = 32
) (
    input logic         frame_clk,
    input logic         Reset_n,
    turn_queue_if.slave bus
);
    localparam int TW = $clog2(QUEUE_TIMEOUT);
    localparam logic [TW-1:0] TMAX = TW'(QUEUE_TIMEOUT - 1);
    localparam logic [9:0] LEAD = 10'(ALIGN_LEAD);

    tq_state_t     state_q, state_d;
    dir_t          cur_q, cur_d, pd_q, pd_d, kdir;
    logic          pv_q, pv_d, kvalid, aligned;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    ko_q, ko_d;
    logic [9:0]    px, py;

    key_decode u_dec (.keycode_i(bus.keycode), .valid_o(kvalid), .dir_o(kdir));

    assign px = bus.BallX + (cur_q == DIR_R ? LEAD : cur_q == DIR_L ? -LEAD : 10'd0);
    assign py = bus.BallY + (cur_q == DIR_D ? LEAD : cur_q == DIR_U ? -LEAD : 10'd0);
    assign aligned = ~|px[TILE_LOG2-1:0] && ~|py[TILE_LOG2-1:0];

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pv_d    = pv_q;
        pd_d    = pd_q;
        tmr_d   = tmr_q;
        if (bus.death || bus.isDefeated) begin
            state_d = TQ_IDLE;
            cur_d   = DIR_R;
            pv_d    = 1'b0;
            pd_d    = DIR_R;
            tmr_d   = '0;
        end else begin
            case (state_q)
                TQ_IDLE: begin
                    state_d = kvalid ? TQ_MOVING : TQ_IDLE;
                    cur_d   = kvalid ? kdir : cur_q;
                end
                TQ_MOVING: begin
                    if (kvalid && kdir != cur_q) begin
                        if (kdir == opposite(cur_q) || aligned) begin
                            cur_d = kdir;
                        end else begin
                            pd_d    = kdir;
                            pv_d    = 1'b1;
                            tmr_d   = '0;
                            state_d = TQ_PENDING;
                        end
                    end
                end
                TQ_PENDING: begin
                    if (kvalid && kdir == opposite(cur_q)) begin
                        cur_d   = kdir;
                        pv_d    = 1'b0;
                        state_d = TQ_MOVING;
                    end else if (kvalid && kdir != cur_q && kdir != pd_q) begin
                        pd_d  = kdir;
                        tmr_d = '0;
                    end else if (aligned) begin
                        cur_d   = pd_q;
                        pv_d    = 1'b0;
                        state_d = TQ_MOVING;
                    end else if (tmr_q == TMAX) begin
                        pv_d    = 1'b0;
                        state_d = TQ_MOVING;
                    end else begin
                        tmr_d = tmr_q + TW'(tmr_q != '1);
                    end
                end
                default: state_d = TQ_IDLE;
            endcase
        end
        ko_d = state_d == TQ_IDLE ? 8'h00 : dir_to_key(cur_d);
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q <= TQ_IDLE;
            cur_q   <= DIR_R;
            pv_q    <= 1'b0;
            pd_q    <= DIR_R;
            tmr_q   <= '0;
            ko_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pv_q    <= pv_d;
            pd_q    <= pd_d;
            tmr_q   <= tmr_d;
            ko_q    <= ko_d;
        end
    end

    assign bus.keycode_out = ko_q;
    assign bus.cur_dir     = cur_q;
    assign bus.pend_valid  = pv_q;
    assign bus.pend_dir    = pd_q;
endmodule

// File: tb/tb_turn_queue.sv
// tb_turn_queue: directed scenarios plus random keys/positions, checked every
// frame against a behavioural model of the turn-queue rules.
module tb_turn_queue;
    logic frame_clk = 1'b0;
    logic Reset_n = 1'b0;
    int vecs = 0;
    int fails = 0;
    turn_queue_if bus ();

    turn_queue dut (.frame_clk(frame_clk), .Reset_n(Reset_n), .bus(bus.slave));

    always #5 frame_clk = ~frame_clk;

    // model: mode 0 idle, 1 moving, 2 pending; directions 0=R 1=D 2=L 3=U
    int m_mode = 0, m_cur = 0, m_pv = 0, m_pd = 0, m_age = 0;
    bit live = 0;
    int keytab[4] = '{8'h07, 8'h16, 8'h04, 8'h1A};

    task automatic chk(string n, int act, int exp);
        vecs++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic int decode(int k);
        for (int i = 0; i < 4; i++) if (keytab[i] == k) return i;
        return -1;
    endfunction

    function automatic bit on_grid(int x, int y, int d);
        int dx = d == 0 ? 1 : d == 2 ? -1 : 0;
        int dy = d == 1 ? 1 : d == 3 ? -1 : 0;
        int nx = ((x + 2 * dx) % 1024 + 1024) % 1024;
        int ny = ((y + 2 * dy) % 1024 + 1024) % 1024;
        return (nx % 8 == 0) && (ny % 8 == 0);
    endfunction

    task automatic model_step(bit rn, int k, int x, int y, bit def, bit dth);
        int kd = decode(k);
        bit al = on_grid(x, y, m_cur);
        if (!rn || dth || def) begin
            m_mode = 0; m_cur = 0; m_pv = 0; m_pd = 0; m_age = 0;
        end else if (m_mode == 0) begin
            if (kd >= 0) begin m_mode = 1; m_cur = kd; end
        end else if (m_mode == 1) begin
            if (kd >= 0 && kd != m_cur) begin
                if (kd == (m_cur + 2) % 4 || al) m_cur = kd;
                else begin m_mode = 2; m_pv = 1; m_pd = kd; m_age = 0; end
            end
        end else begin
            if (kd == (m_cur + 2) % 4) begin m_cur = kd; m_pv = 0; m_mode = 1; end
            else if (kd >= 0 && kd != m_cur && kd != m_pd) begin m_pd = kd; m_age = 0; end
            else if (al) begin m_cur = m_pd; m_pv = 0; m_mode = 1; end
            else if (m_age == 31) begin m_pv = 0; m_mode = 1; end
            else m_age++;
        end
    endtask

    always @(posedge frame_clk) begin
        model_step(Reset_n, int'(bus.keycode), int'(bus.BallX), int'(bus.BallY), bus.isDefeated, bus.death);
        if (!Reset_n) live = 1;
        @(negedge frame_clk);
        if (live) begin
            chk("keycode_out", int'(bus.keycode_out), m_mode == 0 ? 0 : keytab[m_cur]);
            chk("cur_dir", int'(bus.cur_dir), m_cur);
            chk("pend_valid", int'(bus.pend_valid), m_pv);
            if (m_pv != 0) chk("pend_dir", int'(bus.pend_dir), m_pd);
        end
    end

    task automatic step(int k, int x, int y);
        bus.keycode = 8'(k);
        bus.BallX = 10'(x);
        bus.BallY = 10'(y);
        @(negedge frame_clk);
    endtask

    initial begin
        int k, x, y;
        bus.keycode = 8'h00; bus.BallX = '0; bus.BallY = '0;
        bus.isDefeated = 1'b0; bus.death = 1'b0;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_ko", int'(bus.keycode_out), 0);
        chk("rst_pv", int'(bus.pend_valid), 0);
        Reset_n = 1'b1;
        step(8'h07, 133, 251);
        chk("t1_ko", int'(bus.keycode_out), 8'h07);
        chk("t1_dir", int'(bus.cur_dir), 0);
        step(8'h16, 133, 248);
        chk("t2_pv", int'(bus.pend_valid), 1);
        chk("t2_pd", int'(bus.pend_dir), 1);
        chk("t2_ko", int'(bus.keycode_out), 8'h07);
        step(0, 134, 248);
        chk("t2_turn", int'(bus.keycode_out), 8'h16);
        chk("t2_pv0", int'(bus.pend_valid), 0);
        step(8'h07, 128, 246);
        chk("back_r", int'(bus.keycode_out), 8'h07);
        step(8'h04, 131, 248);
        chk("t3_rev", int'(bus.keycode_out), 8'h04);
        chk("t3_pv", int'(bus.pend_valid), 0);
        step(8'h07, 131, 248);
        step(8'h1A, 131, 248);
        chk("t4_pv", int'(bus.pend_valid), 1);
        for (int i = 0; i < 31; i++) step(0, 131, 248);
        chk("t4_hold", int'(bus.pend_valid), 1);
        step(0, 131, 248);
        chk("t4_drop", int'(bus.pend_valid), 0);
        chk("t4_ko", int'(bus.keycode_out), 8'h07);
        step(8'h1A, 131, 248);
        for (int i = 0; i < 31; i++) step(0, 131, 248);
        step(0, 134, 248);
        chk("coinc_turn", int'(bus.keycode_out), 8'h1A);
        step(8'h07, 100, 246);
        step(8'h16, 1022, 0);
        chk("wrap_turn", int'(bus.keycode_out), 8'h16);
        chk("wrap_pv", int'(bus.pend_valid), 0);
        step(8'h07, 1, 0);
        chk("wrap_pend", int'(bus.pend_valid), 1);
        bus.isDefeated = 1'b1;
        step(0, 131, 248);
        chk("t5_ko", int'(bus.keycode_out), 0);
        chk("t5_pv", int'(bus.pend_valid), 0);
        bus.isDefeated = 1'b0;
        step(8'h04, 131, 248);
        chk("t5_go", int'(bus.keycode_out), 8'h04);
        bus.death = 1'b1;
        for (int i = 0; i < 3; i++) step(8'h07, 131, 248);
        chk("t6_death", int'(bus.keycode_out), 0);
        bus.death = 1'b0;
        step(8'h07, 131, 248);
        step(8'h16, 131, 248);
        chk("t6_pend", int'(bus.pend_valid), 1);
        Reset_n = 1'b0;
        step(0, 131, 248);
        chk("t6_rst_ko", int'(bus.keycode_out), 0);
        chk("t6_rst_pv", int'(bus.pend_valid), 0);
        chk("t6_rst_dir", int'(bus.cur_dir), 0);
        Reset_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            k = $urandom_range(0, 9);
            k = k < 5 ? 0 : k < 9 ? keytab[k - 5] : int'($urandom_range(0, 255));
            x = $urandom_range(0, 1023);
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 127)) * 8;
            bus.isDefeated = $urandom_range(0, 99) == 0;
            bus.death = $urandom_range(0, 149) == 0;
            Reset_n = $urandom_range(0, 199) != 0;
            step(k, x, y);
        end
        Reset_n = 1'b1; bus.isDefeated = 1'b0; bus.death = 1'b0;
        step(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
